// File: rtl/wb_byte_master.sv
// Byte-stream driven Wishbone initiator: 'W' A3..A0 D3..D0 -> 'K', 'R' A3..A0 -> R3..R0.
// Optional bus watchdog: define WB_BYTE_MASTER_TIMEOUT_EN (reply 'E' after TIMEOUT_CYCLES without ack).
module wb_byte_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic        busy,
   output logic        rx_drop
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic [31:0] r_reply;
   logic        r_we;
   logic [1:0]  r_cnt;
   logic [1:0]  r_last;
   logic        w_tmo_hit;

`ifdef WB_BYTE_MASTER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tmo;

   // Counter sits at zero outside BUS, so every bus cycle starts from a clean count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tmo <= '0;
      end else if (r_state != S_BUS) begin
         r_tmo <= '0;
      end else if (!wb_ack_i) begin
         r_tmo <= r_tmo + TW'(1);
      end
   end

   assign w_tmo_hit = (r_state == S_BUS) && !wb_ack_i && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
   assign w_tmo_hit    = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (rx_valid && (rx_data == 8'h57 || rx_data == 8'h52)) w_state_next = S_ADDR;
         S_ADDR: if (rx_valid && r_cnt == 2'd3) w_state_next = r_we ? S_DATA : S_BUS;
         S_DATA: if (rx_valid && r_cnt == 2'd3) w_state_next = S_BUS;
         S_BUS:  if (wb_ack_i || w_tmo_hit) w_state_next = S_RESP;
         S_RESP: if (tx_ready && r_cnt == r_last) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // r_cnt wraps 3->0 on the 4th field byte, so it is already clear when ADDR/DATA exit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr  <= '0;
         r_data  <= '0;
         r_reply <= '0;
         r_we    <= 1'b0;
         r_cnt   <= '0;
         r_last  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (rx_valid && rx_data == 8'h57) r_we <= 1'b1;
               else if (rx_valid && rx_data == 8'h52) r_we <= 1'b0;
            end
            S_ADDR: if (rx_valid) begin
               r_addr <= {r_addr[23:0], rx_data};
               r_cnt  <= r_cnt + 2'd1;
            end
            S_DATA: if (rx_valid) begin
               r_data <= {r_data[23:0], rx_data};
               r_cnt  <= r_cnt + 2'd1;
            end
            S_BUS: begin
               r_cnt <= '0;
               if (wb_ack_i) begin
                  r_reply <= r_we ? {8'h4B, 24'h0} : wb_dat_i;
                  r_last  <= r_we ? 2'd0 : 2'd3;
               end else if (w_tmo_hit) begin
                  r_reply <= {8'h45, 24'h0};
                  r_last  <= 2'd0;
               end
            end
            S_RESP: if (tx_ready) begin
               r_reply <= {r_reply[23:0], 8'h00};
               r_cnt   <= r_cnt + 2'd1;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign wb_cyc_o = (r_state == S_BUS);
   assign wb_stb_o = (r_state == S_BUS);
   assign wb_sel_o = wb_cyc_o ? 4'hF : 4'h0;
   assign wb_adr_o = r_addr;
   assign wb_dat_o = r_data;
   assign wb_we_o  = r_we;
   assign tx_valid = (r_state == S_RESP);
   assign tx_data  = tx_valid ? r_reply[31:24] : 8'h00;
   assign busy     = (r_state != S_IDLE);
   assign rx_drop  = rx_valid && (r_state == S_BUS || r_state == S_RESP);

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed self-checking bench for wb_byte_master; covers WB_BYTE_MASTER_TIMEOUT_EN both ways.
module tb_wb_byte_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i = 32'h0;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i = 1'b0;
   logic        busy;
   logic        rx_drop;

   int n_cmp = 0;
   int n_bad = 0;

   wb_byte_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
      .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
      .busy(busy), .rx_drop(rx_drop)
   );

   always #5 clk = ~clk;

   // All tasks start and end just after a falling edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_write(input logic [31:0] adr, input logic [31:0] dat);
      send_byte(8'h57);
      for (int i = 0; i < 4; i++) send_byte(adr[31-8*i -: 8]);
      for (int i = 0; i < 4; i++) send_byte(dat[31-8*i -: 8]);
   endtask

   task automatic send_read(input logic [31:0] adr);
      send_byte(8'h52);
      for (int i = 0; i < 4; i++) send_byte(adr[31-8*i -: 8]);
   endtask

   // Checks the bus phase cycle by cycle and acks in cycle dly; inj_k >= 0 injects a stray byte.
   task automatic bus_cycle(input int dly, input logic [31:0] adr, input logic [31:0] dat,
                            input logic we, input logic [31:0] rd, input int inj_k);
      for (int k = 0; k <= dly; k++) begin
         n_cmp++; if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin n_bad++; $display("FAIL bus_cycstb k=%0d got %b want 11", k, {wb_cyc_o, wb_stb_o}); end
         n_cmp++; if (wb_adr_o !== adr) begin n_bad++; $display("FAIL bus_adr k=%0d got %h want %h", k, wb_adr_o, adr); end
         n_cmp++; if (wb_we_o !== we) begin n_bad++; $display("FAIL bus_we k=%0d got %b want %b", k, wb_we_o, we); end
         n_cmp++; if (wb_sel_o !== 4'hF) begin n_bad++; $display("FAIL bus_sel k=%0d got %h want f", k, wb_sel_o); end
         if (we) begin
            n_cmp++; if (wb_dat_o !== dat) begin n_bad++; $display("FAIL bus_dat k=%0d got %h want %h", k, wb_dat_o, dat); end
         end
         if (k == inj_k) begin
            rx_data = 8'hC3; rx_valid = 1'b1; #1;
            n_cmp++; if (rx_drop !== 1'b1) begin n_bad++; $display("FAIL bus_rx_drop got %b want 1", rx_drop); end
         end
         if (k == dly) begin wb_ack_i = 1'b1; wb_dat_i = rd; end
         @(negedge clk);
         rx_valid = 1'b0;
         wb_ack_i = 1'b0;
      end
      n_cmp++; if ({wb_cyc_o, wb_stb_o, tx_valid} !== 3'b001) begin n_bad++; $display("FAIL bus_end cyc/stb/txv got %b want 001", {wb_cyc_o, wb_stb_o, tx_valid}); end
   endtask

   // Collects n reply bytes (MSB-aligned in exp), stalling tx_ready low for 'stall' cycles per byte.
   task automatic recv_reply(input int n, input logic [31:0] exp, input int stall, input logic inj_last);
      logic [7:0] eb;
      for (int i = 0; i < n; i++) begin
         eb = exp[31-8*i -: 8];
         for (int s = 0; s < stall; s++) begin
            tx_ready = 1'b0;
            n_cmp++; if ({tx_valid, busy, tx_data} !== {2'b11, eb}) begin n_bad++; $display("FAIL stall_hold i=%0d got v%b b%b %h want v1 b1 %h", i, tx_valid, busy, tx_data, eb); end
            @(negedge clk);
         end
         tx_ready = 1'b1;
         n_cmp++; if ({tx_valid, tx_data} !== {1'b1, eb}) begin n_bad++; $display("FAIL reply_byte i=%0d got v%b %h want v1 %h", i, tx_valid, tx_data, eb); end
         if (inj_last && i == n - 1) begin
            rx_data = 8'h52; rx_valid = 1'b1; #1;
            n_cmp++; if (rx_drop !== 1'b1) begin n_bad++; $display("FAIL final_hs_drop got %b want 1", rx_drop); end
         end
         @(negedge clk);
         rx_valid = 1'b0;
      end
      tx_ready = 1'b0;
      n_cmp++; if ({tx_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL reply_end txv/busy got %b want 00", {tx_valid, busy}); end
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'h0) begin n_bad++; $display("FAIL rst_wb_ctl got %b want 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
      n_cmp++; if ({wb_adr_o, wb_dat_o} !== 64'h0) begin n_bad++; $display("FAIL rst_wb_bus got %h want 0", {wb_adr_o, wb_dat_o}); end
      n_cmp++; if ({tx_valid, tx_data, busy, rx_drop} !== 11'h0) begin n_bad++; $display("FAIL rst_misc got %h want 0", {tx_valid, tx_data, busy, rx_drop}); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("reset: outputs checked");
   endtask

   task automatic test_write();
      send_write(32'h4000_0000, 32'h0000_00A5);
      bus_cycle(3, 32'h4000_0000, 32'h0000_00A5, 1'b1, 32'h0, -1);
      recv_reply(1, 32'h4B00_0000, 0, 1'b0);
      $display("write adr=40000000 dat=000000a5 reply 4b");
   endtask

   task automatic test_read();
      send_read(32'h2000_0004);
      bus_cycle(1, 32'h2000_0004, 32'h0, 1'b0, 32'h1234_5678, -1);
      recv_reply(4, 32'h1234_5678, 0, 1'b0);
      $display("read adr=20000004 reply 12345678");
   endtask

   task automatic test_read_stall();
      send_read(32'h2000_0004);
      bus_cycle(0, 32'h2000_0004, 32'h0, 1'b0, 32'h1234_5678, -1);
      recv_reply(4, 32'h1234_5678, 5, 1'b0);
      $display("read adr=20000004 stalled reply 12345678");
   endtask

   task automatic test_junk_and_drop();
      rx_data = 8'h00; rx_valid = 1'b1; #1;
      n_cmp++; if ({rx_drop, busy} !== 2'b00) begin n_bad++; $display("FAIL junk00 drop/busy got %b want 00", {rx_drop, busy}); end
      @(negedge clk);
      rx_data = 8'hFF; #1;
      n_cmp++; if ({rx_drop, busy} !== 2'b00) begin n_bad++; $display("FAIL junkFF drop/busy got %b want 00", {rx_drop, busy}); end
      @(negedge clk);
      rx_valid = 1'b0;
      n_cmp++; if ({busy, wb_cyc_o} !== 2'b00) begin n_bad++; $display("FAIL junk_idle busy/cyc got %b want 00", {busy, wb_cyc_o}); end
      send_read(32'h0000_0010);
      bus_cycle(3, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1);
      recv_reply(4, 32'hDEAD_BEEF, 0, 1'b1);
      $display("junk 00 ff ignored, read adr=00000010 reply deadbeef with drops");
   endtask

   task automatic test_timeout();
      int lost;
      send_write(32'h0000_0100, 32'hCAFE_F00D);
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
      for (int k = 0; k < 16; k++) begin
         n_cmp++; if (wb_cyc_o !== 1'b1) begin n_bad++; $display("FAIL tmo_cyc_high k=%0d got %b want 1", k, wb_cyc_o); end
         @(negedge clk);
      end
      n_cmp++; if ({wb_cyc_o, tx_valid} !== 2'b01) begin n_bad++; $display("FAIL tmo_end cyc/txv got %b want 01", {wb_cyc_o, tx_valid}); end
      recv_reply(1, 32'h4500_0000, 0, 1'b0);
      $display("timeout write: reply 45 after 16 cycles");
`else
      lost = 0;
      for (int k = 0; k < 10000; k++) begin
         if (wb_cyc_o !== 1'b1) lost++;
         @(negedge clk);
      end
      n_cmp++; if ({lost, wb_cyc_o} !== {32'd0, 1'b1}) begin n_bad++; $display("FAIL no_tmo cyc low cycles got %0d (cyc=%b) want 0 (cyc=1)", lost, wb_cyc_o); end
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("no timeout: cyc held for 10000 cycles");
`endif
   endtask

   task automatic test_reset_midway();
      send_write(32'h0000_0200, 32'h1111_2222);
      @(negedge clk);
      #2 reset = 1'b1; #1;
      n_cmp++; if ({wb_cyc_o, wb_stb_o, tx_valid, busy} !== 4'b0000) begin n_bad++; $display("FAIL rst_in_bus got %b want 0000", {wb_cyc_o, wb_stb_o, tx_valid, busy}); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send_read(32'h0000_0300);
      bus_cycle(0, 32'h0000_0300, 32'h0, 1'b0, 32'hA1B2_C3D4, -1);
      #2 reset = 1'b1; #1;
      n_cmp++; if ({wb_cyc_o, wb_stb_o, tx_valid, busy} !== 4'b0000) begin n_bad++; $display("FAIL rst_in_resp got %b want 0000", {wb_cyc_o, wb_stb_o, tx_valid, busy}); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send_write(32'h8000_000C, 32'h0BAD_F00D);
      bus_cycle(2, 32'h8000_000C, 32'h0BAD_F00D, 1'b1, 32'h0, -1);
      recv_reply(1, 32'h4B00_0000, 0, 1'b0);
      send_read(32'h8000_000C);
      bus_cycle(1, 32'h8000_000C, 32'h0, 1'b0, 32'h55AA_00FF, -1);
      recv_reply(4, 32'h55AA_00FF, 1, 1'b0);
      $display("reset in BUS/RESP, then write+read recovered");
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_read_stall();
      test_junk_and_drop();
      test_timeout();
      test_reset_midway();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
